// File: rtl/rob_finish_table.sv
// rob_finish_table: ROB-side responder for the FU_ROB finish interface.
// Tracks per-entry valid/finished state and tells commit whether the two
// oldest entries (head, head+1) are ready to retire.
//
// Ports:
//   clk, rst        core clock, asynchronous active-low reset
//   flush           synchronous clear of all entry state (err_spurious kept)
//   alloc_en[1:0]   dispatch allocation per lane, ids alloc_id0/alloc_id1
//   fu_setFinish    per-FU finish strobe, ids packed in fu_id (k*ID_W +: ID_W)
//   head_id         current ROB head
//   commit_pop[1:0] retire head (bit0) and head+1 (bit1, only with bit0)
//   head_finished   {head+1, head} valid & finished
//   pending_cnt     number of entries valid and not yet finished
//   err_spurious    sticky: a finish strobe hit an invalid entry
//
// Optional feature: define FINISH_BYPASS_EN to forward same-cycle finish
// strobes straight onto head_finished (0-cycle finish-to-commit latency).

module rob_finish_table #(
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned ID_W      = 5,
  parameter int unsigned NUM_FU    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             alloc_en,
  input  logic [ID_W-1:0]        alloc_id0,
  input  logic [ID_W-1:0]        alloc_id1,
  input  logic [NUM_FU-1:0]      fu_setFinish,
  input  logic [NUM_FU*ID_W-1:0] fu_id,
  input  logic [ID_W-1:0]        head_id,
  input  logic [1:0]             commit_pop,
  output logic [1:0]             head_finished,
  output logic [ID_W:0]          pending_cnt,
  output logic                   err_spurious
);

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] fin_q, fin_d;
  logic [ROB_DEPTH-1:0] new_fin;
  logic [ID_W:0]        pending_q, pending_d;
  logic [ID_W:0]        alloc_cnt, fin_cnt;
  logic                 err_q, err_d;
  logic [ID_W-1:0]      head1_id;
  logic [ID_W-1:0]      upd_id;

  // Natural ID_W-bit wrap gives (head_id + 1) mod ROB_DEPTH.
  assign head1_id = head_id + ID_W'(1);

  always_comb begin
    valid_d   = valid_q;
    fin_d     = fin_q;
    new_fin   = '0;
    err_d     = err_q;
    alloc_cnt = '0;
    fin_cnt   = '0;
    upd_id    = '0;

    // Finishes are judged against the current (old) valid bits.
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      upd_id = fu_id[k*ID_W +: ID_W];
      if (fu_setFinish[k]) begin
        if (valid_q[upd_id]) begin
          // Mask, not counter: duplicate strobes to one id count once.
          if (!fin_q[upd_id]) new_fin[upd_id] = 1'b1;
          fin_d[upd_id] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Popped entries are already finished, so they never touch the count.
    if (commit_pop[0]) begin
      valid_d[head_id] = 1'b0;
      fin_d[head_id]   = 1'b0;
      if (commit_pop[1]) begin
        valid_d[head1_id] = 1'b0;
        fin_d[head1_id]   = 1'b0;
      end
    end

    // Allocation overrides both a same-cycle finish and a same-cycle pop.
    if (alloc_en[0]) begin
      valid_d[alloc_id0] = 1'b1;
      fin_d[alloc_id0]   = 1'b0;
      new_fin[alloc_id0] = 1'b0;
      alloc_cnt          = alloc_cnt + (ID_W+1)'(1);
    end
    if (alloc_en[1]) begin
      valid_d[alloc_id1] = 1'b1;
      fin_d[alloc_id1]   = 1'b0;
      new_fin[alloc_id1] = 1'b0;
      alloc_cnt          = alloc_cnt + (ID_W+1)'(1);
    end

    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      fin_cnt = fin_cnt + {{ID_W{1'b0}}, new_fin[i]};
    end

    pending_d = pending_q + alloc_cnt - fin_cnt;

    if (flush) begin
      valid_d   = '0;
      fin_d     = '0;
      pending_d = '0;
      err_d     = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      fin_q     <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      fin_q     <= fin_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

`ifdef FINISH_BYPASS_EN
  logic [ID_W-1:0] byp_id;

  always_comb begin
    head_finished[0] = valid_q[head_id] & fin_q[head_id];
    head_finished[1] = valid_q[head1_id] & fin_q[head1_id];
    byp_id           = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      byp_id = fu_id[k*ID_W +: ID_W];
      if (fu_setFinish[k] && (byp_id == head_id) && valid_q[head_id]) begin
        head_finished[0] = 1'b1;
      end
      if (fu_setFinish[k] && (byp_id == head1_id) && valid_q[head1_id]) begin
        head_finished[1] = 1'b1;
      end
    end
    if (flush) head_finished = 2'b00;
  end
`else
  always_comb begin
    head_finished[0] = valid_q[head_id] & fin_q[head_id];
    head_finished[1] = valid_q[head1_id] & fin_q[head1_id];
  end
`endif

  assign pending_cnt  = pending_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_rob_finish_table.sv
module tb_rob_finish_table;
  localparam int D = 32;
  localparam int W = 5;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [1:0]     alloc_en;
  logic [W-1:0]   alloc_id0, alloc_id1;
  logic [N-1:0]   fu_setFinish;
  logic [N*W-1:0] fu_id;
  logic [W-1:0]   head_id;
  logic [1:0]     commit_pop;
  logic [1:0]     head_finished;
  logic [W:0]     pending_cnt;
  logic           err_spurious;

  int checks = 0;
  int errors = 0;

  // Reference model: the ROB as plain bit sets.
  bit [D-1:0] m_valid, m_fin;
  bit         m_err;
  int         rh, rcnt;  // bench-side head pointer / occupancy for random legal traffic

  rob_finish_table #(.ROB_DEPTH(D), .ID_W(W), .NUM_FU(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_en     (alloc_en),
    .alloc_id0    (alloc_id0),
    .alloc_id1    (alloc_id1),
    .fu_setFinish (fu_setFinish),
    .fu_id        (fu_id),
    .head_id      (head_id),
    .commit_pop   (commit_pop),
    .head_finished(head_finished),
    .pending_cnt  (pending_cnt),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  function automatic int m_pend();
    int c = 0;
    for (int i = 0; i < D; i++) if (m_valid[i] && !m_fin[i]) c++;
    return c;
  endfunction

  function automatic logic [1:0] m_hf();
    int h  = int'(head_id);
    int h1 = (h + 1) % D;
    logic [1:0] r;
    r[0] = m_valid[h] & m_fin[h];
    r[1] = m_valid[h1] & m_fin[h1];
`ifdef FINISH_BYPASS_EN
    for (int k = 0; k < N; k++) begin
      if (fu_setFinish[k]) begin
        if (int'(fu_id[k*W +: W]) == h && m_valid[h]) r[0] = 1'b1;
        if (int'(fu_id[k*W +: W]) == h1 && m_valid[h1]) r[1] = 1'b1;
      end
    end
    if (flush) r = 2'b00;
`endif
    return r;
  endfunction

  task automatic idle();
    flush = 0; alloc_en = 0; alloc_id0 = 0; alloc_id1 = 0;
    fu_setFinish = 0; fu_id = 0; commit_pop = 0;
  endtask

  task automatic set_fin(input int k, input int id);
    fu_setFinish[k] = 1'b1;
    fu_id[k*W +: W] = W'(id);
  endtask

  task automatic m_clear();
    m_valid = '0; m_fin = '0; m_err = 0; rh = 0; rcnt = 0;
  endtask

  // Advance one clock edge and apply the rules to the model.
  task automatic tick();
    bit [D-1:0] nv = m_valid;
    bit [D-1:0] nf = m_fin;
    bit ne = m_err;
    int h = int'(head_id);
    if (flush) begin
      nv = '0; nf = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (fu_setFinish[k]) begin
          if (m_valid[fu_id[k*W +: W]]) nf[fu_id[k*W +: W]] = 1'b1;
          else ne = 1'b1;
        end
      end
      if (commit_pop[0]) begin
        nv[h] = 0; nf[h] = 0;
        if (commit_pop[1]) begin nv[(h+1)%D] = 0; nf[(h+1)%D] = 0; end
      end
      if (alloc_en[0]) begin nv[alloc_id0] = 1; nf[alloc_id0] = 0; end
      if (alloc_en[1]) begin nv[alloc_id1] = 1; nf[alloc_id1] = 0; end
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_fin = nf; m_err = ne;
  endtask

  task automatic do_reset();
    idle(); head_id = 0;
    rst = 0;
    m_clear();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; idle(); head_id = 0; m_clear();
    #1;
    checks++; if (head_finished !== 2'b00) begin errors++;
      $display("FAIL reset_hf got %b exp 00", head_finished); end
    checks++; if (pending_cnt !== 0) begin errors++;
      $display("FAIL reset_pend got %0d exp 0", pending_cnt); end
    checks++; if (err_spurious !== 1'b0) begin errors++;
      $display("FAIL reset_err got %b exp 0", err_spurious); end
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_basic();
    idle(); head_id = 0;
    alloc_en = 2'b11; alloc_id0 = 0; alloc_id1 = 1;
    tick(); idle();
    #1;
    checks++; if (pending_cnt !== 2) begin errors++;
      $display("FAIL basic_alloc_pend got %0d exp 2", pending_cnt); end
    checks++; if (head_finished !== 2'b00) begin errors++;
      $display("FAIL basic_alloc_hf got %b exp 00", head_finished); end
    set_fin(0, 1);
    #1;
    checks++; if (head_finished !== m_hf()) begin errors++;
      $display("FAIL basic_fin1_sameclk got %b exp %b", head_finished, m_hf()); end
    tick(); idle();
    #1;
    checks++; if (head_finished !== 2'b10) begin errors++;
      $display("FAIL basic_fin1_hf got %b exp 10", head_finished); end
    checks++; if (pending_cnt !== 1) begin errors++;
      $display("FAIL basic_fin1_pend got %0d exp 1", pending_cnt); end
    set_fin(2, 0);
    #1;
    checks++; if (head_finished !== m_hf()) begin errors++;
      $display("FAIL basic_fin0_sameclk got %b exp %b", head_finished, m_hf()); end
    tick(); idle();
    #1;
    checks++; if (head_finished !== 2'b11) begin errors++;
      $display("FAIL basic_fin0_hf got %b exp 11", head_finished); end
    checks++; if (pending_cnt !== 0) begin errors++;
      $display("FAIL basic_fin0_pend got %0d exp 0", pending_cnt); end
    // Lone bit1 pop must be ignored.
    commit_pop = 2'b10;
    tick(); idle();
    #1;
    checks++; if (head_finished !== 2'b11) begin errors++;
      $display("FAIL basic_pop10_ignored got %b exp 11", head_finished); end
  endtask

  task automatic test_wrap_dup();
    do_reset();
    head_id = 31;
    alloc_en = 2'b11; alloc_id0 = 31; alloc_id1 = 0;
    tick(); idle();
    #1;
    checks++; if (pending_cnt !== 2) begin errors++;
      $display("FAIL wrap_alloc_pend got %0d exp 2", pending_cnt); end
    set_fin(0, 0); set_fin(1, 0);
    tick(); idle();
    #1;
    checks++; if (head_finished !== 2'b10) begin errors++;
      $display("FAIL wrap_dup_hf got %b exp 10", head_finished); end
    checks++; if (pending_cnt !== 1) begin errors++;
      $display("FAIL wrap_dup_pend got %0d exp 1", pending_cnt); end
    // Re-finishing an already finished entry must not decrement again.
    set_fin(3, 0);
    tick(); idle();
    #1;
    checks++; if (pending_cnt !== 1) begin errors++;
      $display("FAIL wrap_refin_pend got %0d exp 1", pending_cnt); end
  endtask

  task automatic test_spurious();
    do_reset();
    alloc_en = 2'b01; alloc_id0 = 0;
    tick(); idle();
    set_fin(3, 7);
    tick(); idle();
    #1;
    checks++; if (err_spurious !== 1'b1) begin errors++;
      $display("FAIL spur_set got %b exp 1", err_spurious); end
    checks++; if (pending_cnt !== 1) begin errors++;
      $display("FAIL spur_pend got %0d exp 1", pending_cnt); end
    tick();
    checks++; if (err_spurious !== 1'b1) begin errors++;
      $display("FAIL spur_sticky got %b exp 1", err_spurious); end
    flush = 1;
    tick(); idle();
    #1;
    checks++; if (err_spurious !== 1'b1) begin errors++;
      $display("FAIL spur_after_flush got %b exp 1", err_spurious); end
    rst = 0;
    #1;
    checks++; if (err_spurious !== 1'b0) begin errors++;
      $display("FAIL spur_reset got %b exp 0", err_spurious); end
    m_clear();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_flush();
    do_reset();
    alloc_en = 2'b11; alloc_id0 = 0; alloc_id1 = 1;
    tick();
    alloc_id0 = 2; alloc_id1 = 3;
    tick(); idle();
    set_fin(0, 0); set_fin(1, 2);
    tick(); idle();
    #1;
    checks++; if (pending_cnt !== 2) begin errors++;
      $display("FAIL flush_pre_pend got %0d exp 2", pending_cnt); end
    flush = 1; alloc_en = 2'b11; alloc_id0 = 4; alloc_id1 = 5;
    #1;
    checks++; if (head_finished !== m_hf()) begin errors++;
      $display("FAIL flush_sameclk_hf got %b exp %b", head_finished, m_hf()); end
    tick(); idle();
    #1;
    checks++; if (pending_cnt !== 0) begin errors++;
      $display("FAIL flush_pend got %0d exp 0", pending_cnt); end
    checks++; if (head_finished !== 2'b00) begin errors++;
      $display("FAIL flush_hf got %b exp 00", head_finished); end
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc_en = 2'b11; alloc_id0 = 0; alloc_id1 = 1;
    tick();
    alloc_en = 2'b01; alloc_id0 = 2;
    tick(); idle();
    set_fin(0, 0); set_fin(1, 1); set_fin(2, 9);
    tick(); idle();
    #1;
    checks++; if (head_finished !== 2'b11 || pending_cnt !== 1 || err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got hf=%b pend=%0d err=%b exp 11/1/1",
               head_finished, pending_cnt, err_spurious);
    end
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    checks++; if (head_finished !== 2'b00) begin errors++;
      $display("FAIL async_hf got %b exp 00", head_finished); end
    checks++; if (pending_cnt !== 0) begin errors++;
      $display("FAIL async_pend got %0d exp 0", pending_cnt); end
    checks++; if (err_spurious !== 1'b0) begin errors++;
      $display("FAIL async_err got %b exp 0", err_spurious); end
    m_clear();
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_pop();
    do_reset();
    head_id = 5;
    alloc_en = 2'b11; alloc_id0 = 5; alloc_id1 = 6;
    tick(); idle();
    set_fin(1, 5); set_fin(3, 6);
    tick(); idle();
    #1;
    checks++; if (head_finished !== 2'b11) begin errors++;
      $display("FAIL pop_pre_hf got %b exp 11", head_finished); end
    commit_pop = 2'b11;
    tick(); idle();
    #1;
    checks++; if (head_finished !== 2'b00) begin errors++;
      $display("FAIL pop_hf got %b exp 00", head_finished); end
    checks++; if (pending_cnt !== 0) begin errors++;
      $display("FAIL pop_pend got %0d exp 0", pending_cnt); end
  endtask

  task automatic test_random();
    int popn, an, tail, fr, r;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      head_id = W'(rh);
      popn = 0;
      if (rcnt >= 1 && m_valid[rh] && m_fin[rh] && $urandom_range(3) != 0) begin
        commit_pop[0] = 1; popn = 1;
        if (rcnt >= 2 && m_valid[(rh+1)%D] && m_fin[(rh+1)%D] && $urandom_range(1) == 1) begin
          commit_pop[1] = 1; popn = 2;
        end
      end else if ($urandom_range(7) == 0) begin
        commit_pop = 2'b10;
      end
      tail = (rh + rcnt) % D;
      fr = D - rcnt;
      an = 0;
      r = int'($urandom_range(3));
      if (r == 1 && fr >= 1) begin
        alloc_en = 2'b01; alloc_id0 = W'(tail); an = 1;
      end else if (r == 2 && fr >= 1) begin
        alloc_en = 2'b10; alloc_id1 = W'(tail); an = 1;
      end else if (r == 3 && fr >= 2) begin
        alloc_en = 2'b11; alloc_id0 = W'(tail); alloc_id1 = W'((tail+1)%D); an = 2;
      end
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(2) == 0) begin
          if (rcnt > 0 && $urandom_range(19) != 0)
            set_fin(k, (rh + int'($urandom_range(rcnt-1))) % D);
          else
            set_fin(k, int'($urandom_range(D-1)));
        end
      end
      if ($urandom_range(49) == 0) flush = 1;
      #1;
      checks++; if (head_finished !== m_hf()) begin errors++;
        $display("FAIL rand_hf cyc %0d got %b exp %b", cyc, head_finished, m_hf()); end
      if (flush) begin
        rcnt = 0;
        tick();
      end else begin
        tick();
        rh = (rh + popn) % D;
        rcnt = rcnt + an - popn;
      end
      checks++; if (pending_cnt !== (W+1)'(m_pend())) begin errors++;
        $display("FAIL rand_pend cyc %0d got %0d exp %0d", cyc, pending_cnt, m_pend()); end
      checks++; if (err_spurious !== m_err) begin errors++;
        $display("FAIL rand_err cyc %0d got %b exp %b", cyc, err_spurious, m_err); end
    end
  endtask

  initial begin
    rst = 0;
    idle();
    head_id = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_wrap_dup();
    test_spurious();
    test_flush();
    test_async_reset();
    test_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
